button_input: RTL and testbench
===============================

# button_input

Input-side companion to the LED output logic: conditions up to `N` raw, active-low push-buttons on the board into clean, debounced press state and single-cycle press/release events. Each button has a 2-flop synchronizer followed by an independent debounce state machine. Downstream logic, such as the LED pattern generators and mode selectors, consumes `pressed` as a level or `press`/`release` as strobes.

## Interface
- `N`, default 4: number of buttons, 1 to 32.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronized samples required to accept a level change. Must be ≥ 2.
- `REPEAT_DELAY`, default 25000000: cycles held before the first auto-repeat. Used only with `BUTTON_REPEAT_EN`.
- `REPEAT_PERIOD`, default 5000000: cycles between auto-repeat pulses. Used only with `BUTTON_REPEAT_EN`. Must be ≥ 2.
- `clk` input 1: single clock; all logic is on its rising edge.
- `nreset` input 1: asynchronous, active-low reset.
- `btn_n` input N: raw, asynchronous button pins; 0 = pressed.
- `pressed` output N: debounced level; 1 = pressed.
- `press` output N: one-cycle strobe on accepted press, and on auto-repeat when enabled.
- `release` output N: one-cycle strobe on accepted release.

## Operation
- **Reset** (`nreset` = 0, asynchronous):
  - Synchronizer flops reset to 1 (released).
  - All counters reset to 0.
  - All states reset to RELEASED.
  - `pressed`, `press` and `release` reset to 0.
- **Synchronizer:** `btn_n` passes through 2 flops and is inverted to `s` (1 = pressed). Nothing downstream reads `btn_n` directly.
- **Per-button FSM:** RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
  - RELEASED: if `s`=1, go to PRESS_PEND with counter=1.
  - PRESS_PEND:
    - If `s`=0, return to RELEASED and clear the counter. The glitch is discarded with no strobe.
    - Otherwise, if counter == `DEBOUNCE_CYCLES`−1, go to PRESSED. Set `pressed`=1 and assert `press` for 1 cycle.
    - Otherwise, increment the counter.
  - PRESSED: if `s`=0, go to RELEASE_PEND with counter=1.
  - RELEASE_PEND:
    - If `s`=1, return to PRESSED with no strobe.
    - Otherwise, if counter == `DEBOUNCE_CYCLES`−1, go to RELEASED. Set `pressed`=0 and assert `release` for 1 cycle.
    - Otherwise, increment the counter.
- **Counter:** width is `$clog2` of the largest used count. It never wraps, because it is cleared on every state change.
- **Independence:** buttons do not interact. Any combination may change or emit strobes in the same cycle.
- **Strobe exclusivity:** `press` and `release` are never both 1 for the same bit in the same cycle.
- **Reset mid-operation:** any state returns to RELEASED with no `release` strobe. If a button is still held after reset deasserts, it is detected as a new press after full latency.

## Timing
- **Latency:** the new level is first sampled at edge k. `pressed` and the strobe change on edge k+1+`DEBOUNCE_CYCLES`.
- **Registered outputs:** all outputs come straight from flops with no combinational path from `btn_n`.
- **Strobe width:** exactly 1 `clk` cycle, aligned with the `pressed` transition edge.
- **Minimum accepted pulse:** an input level held for fewer than `DEBOUNCE_CYCLES` consecutive synchronized samples produces no output change.
- **Event spacing:** the minimum spacing between a `press` and the following `release` on one bit is `DEBOUNCE_CYCLES` cycles.

## Configuration
- **`BUTTON_REPEAT_EN` defined:**
  - PRESSED has sub-phases HOLD and REPEAT.
  - After `REPEAT_DELAY` cycles continuously in PRESSED (counted from the accept edge), `press` pulses once.
  - After that, `press` pulses every `REPEAT_PERIOD` cycles while the button remains held.
  - Entering RELEASE_PEND freezes the repeat counter. Returning to PRESSED from a rejected release resumes it without restarting.
  - Accepted release clears the repeat counter.
- **`BUTTON_REPEAT_EN` undefined:**
  - No repeat logic or counters are synthesized.
  - `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.
  - `press` fires exactly once per accepted press.

## Test plan
Bench parameters: `N`=4, `DEBOUNCE_CYCLES`=8, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=5.

1. **Reset values:** assert `nreset`=0 mid-cycle with `btn_n`=4'b0000 → outputs are 0 immediately and asynchronously. Release reset → `pressed`=4'b1111 and `press`=4'b1111 for one cycle, 9 edges after the first sampling edge, with no `release` strobe.
2. **Clean press:** drive `btn_n[0]`=0 from edge k → `pressed[0]` rises at edge k+9. `press[0]` is high for exactly that cycle. Other bits stay 0.
3. **Rejected glitches:** drive `btn_n[1]` low for 7 cycles, then high → no change on any output. Drive a 7-cycle high glitch while `pressed[1]`=1 → `pressed[1]` stays 1 with no strobes.
4. **Simultaneous events:** press bits 2 and 3 on the same edge → both `press` bits pulse on the same cycle. Release bit 2 while pressing bit 0 on the same edge → `release[2]` and `press[0]` pulse on the same cycle.
5. **Reset while pending:** assert reset at counter=5 in PRESS_PEND → counter clears and no strobe follows. A full 8-sample hold after reset is then required for `press`.
6. **Auto-repeat** (`BUTTON_REPEAT_EN` defined): hold bit 0 → `press[0]` pulses at accept, accept+20, accept+25, accept+30. Without the macro, a 60-cycle hold gives exactly one `press` pulse.

Source files
------------

// File: rtl/button_input_if.sv
// button_input_if: groups the raw button pins with the debounced
// level and strobe outputs of button_input.
// The DUT side uses the slave modport. The driving/consuming side uses master.
interface button_input_if #(
  parameter int N = 4
);

  logic [N-1:0] i_btn_n;
  logic [N-1:0] o_pressed;
  logic [N-1:0] o_press;
  logic [N-1:0] o_release;

  modport master (
    output i_btn_n,
    input  o_pressed,
    input  o_press,
    input  o_release
  );

  modport slave (
    input  i_btn_n,
    output o_pressed,
    output o_press,
    output o_release
  );

endinterface

// File: rtl/button_input.sv
// button_input: conditions N raw active-low push-buttons into a debounced
// pressed level plus single-cycle press/release strobes.
// Each button has a 2-flop synchronizer and its own debounce FSM.
// Optional feature macro: BUTTON_REPEAT_EN adds hold-to-repeat press strobes.
// When the macro is undefined, no repeat logic or counters exist.
module button_input #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic           clk,
  input  logic           nreset,
  button_input_if.slave  bus
);

  // The debounce counter only ever reaches DEBOUNCE_CYCLES-1.
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_PEND,
    ST_PRESSED,
    ST_RELEASE_PEND
  } state_t;

  if (N < 1 || N > 32) begin : g_chk_n
    $error("button_input: N must be between 1 and 32");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
    $error("button_input: DEBOUNCE_CYCLES must be at least 2");
  end

`ifdef BUTTON_REPEAT_EN
  // The repeat counter is shared by the HOLD and REPEAT sub-phases.
  // It is sized for the longer of the two intervals.
  localparam int RMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMax < 2) ? 1 : $clog2(RMax);
  localparam logic [RW-1:0] DelayLast  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PeriodLast = RW'(REPEAT_PERIOD - 1);

  typedef enum logic {
    PH_HOLD,
    PH_REPEAT
  } phase_t;

  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 2) begin : g_chk_rep
    $error("button_input: REPEAT_DELAY must be >= 1 and REPEAT_PERIOD >= 2");
  end
`else
  if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_chk_rep
    $error("button_input: repeat parameters must not be negative");
  end
`endif

  logic [N-1:0] r_sync1;
  logic [N-1:0] r_sync2;
  logic [N-1:0] w_s;
  logic [N-1:0] w_pressed;
  logic [N-1:0] w_press;
  logic [N-1:0] w_release;

  // Two-flop synchronizer. It resets to "released" so a held button after reset
  // must go through the full debounce again.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= bus.i_btn_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = ~r_sync2;

  for (genvar gi = 0; gi < N; gi++) begin : g_btn

    state_t        r_state;
    state_t        w_stateNext;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cntNext;
    logic          r_pressed;
    logic          w_pressedNext;
    logic          r_press;
    logic          w_pressNext;
    logic          r_release;
    logic          w_releaseNext;
`ifdef BUTTON_REPEAT_EN
    logic [RW-1:0] r_rep;
    logic [RW-1:0] w_repNext;
    phase_t        r_phase;
    phase_t        w_phaseNext;
`endif

    // Per-button state, counters and registered outputs.
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        r_state   <= ST_RELEASED;
        r_cnt     <= '0;
        r_pressed <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
`ifdef BUTTON_REPEAT_EN
        r_rep     <= '0;
        r_phase   <= PH_HOLD;
`endif
      end else begin
        r_state   <= w_stateNext;
        r_cnt     <= w_cntNext;
        r_pressed <= w_pressedNext;
        r_press   <= w_pressNext;
        r_release <= w_releaseNext;
`ifdef BUTTON_REPEAT_EN
        r_rep     <= w_repNext;
        r_phase   <= w_phaseNext;
`endif
      end
    end

    // Debounce next-state logic. A level change is accepted only after
    // DEBOUNCE_CYCLES consecutive agreeing samples. Strobes default low.
    always_comb begin
      w_stateNext   = r_state;
      w_cntNext     = r_cnt;
      w_pressedNext = r_pressed;
      w_pressNext   = 1'b0;
      w_releaseNext = 1'b0;
`ifdef BUTTON_REPEAT_EN
      w_repNext     = r_rep;
      w_phaseNext   = r_phase;
`endif
      case (r_state)
        ST_RELEASED: begin
          if (w_s[gi]) begin
            w_stateNext = ST_PRESS_PEND;
            w_cntNext   = CntOne;
          end
        end
        ST_PRESS_PEND: begin
          if (!w_s[gi]) begin
            w_stateNext = ST_RELEASED;
            w_cntNext   = '0;
          end else if (r_cnt == CntLast) begin
            w_stateNext   = ST_PRESSED;
            w_cntNext     = '0;
            w_pressedNext = 1'b1;
            w_pressNext   = 1'b1;
`ifdef BUTTON_REPEAT_EN
            w_repNext     = '0;
            w_phaseNext   = PH_HOLD;
`endif
          end else begin
            w_cntNext = r_cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!w_s[gi]) begin
            w_stateNext = ST_RELEASE_PEND;
            w_cntNext   = CntOne;
          end else begin
`ifdef BUTTON_REPEAT_EN
            if (r_phase == PH_HOLD) begin
              if (r_rep == DelayLast) begin
                w_pressNext = 1'b1;
                w_repNext   = '0;
                w_phaseNext = PH_REPEAT;
              end else begin
                w_repNext = r_rep + 1'b1;
              end
            end else begin
              if (r_rep == PeriodLast) begin
                w_pressNext = 1'b1;
                w_repNext   = '0;
              end else begin
                w_repNext = r_rep + 1'b1;
              end
            end
`endif
          end
        end
        ST_RELEASE_PEND: begin
          if (w_s[gi]) begin
            w_stateNext = ST_PRESSED;
            w_cntNext   = '0;
          end else if (r_cnt == CntLast) begin
            w_stateNext   = ST_RELEASED;
            w_cntNext     = '0;
            w_pressedNext = 1'b0;
            w_releaseNext = 1'b1;
`ifdef BUTTON_REPEAT_EN
            w_repNext     = '0;
            w_phaseNext   = PH_HOLD;
`endif
          end else begin
            w_cntNext = r_cnt + 1'b1;
          end
        end
        default: begin
          w_stateNext = ST_RELEASED;
          w_cntNext   = '0;
        end
      endcase
    end

    assign w_pressed[gi] = r_pressed;
    assign w_press[gi]   = r_press;
    assign w_release[gi] = r_release;

  end

  assign bus.o_pressed = w_pressed;
  assign bus.o_press   = w_press;
  assign bus.o_release = w_release;

endmodule

// File: tb/tb_button_input.sv
// tb_button_input: directed vectors for button_input with N=4,
// DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5.
// Inputs are driven and outputs are checked 1 time unit after each falling clock edge.
// A step is one such point. A level applied at step 0 becomes visible at step 10.
module tb_button_input;

  logic clk = 1'b0;
  logic nreset;
  int   vectorCount = 0;
  int   failCount   = 0;
  int   pressCount[4]   = '{default: 0};
  int   releaseCount[4] = '{default: 0};
  int   p0;
  int   p1;
  int   r1;
  int   p3;

  button_input_if #(.N(4)) bus ();

  button_input #(
    .N(4),
    .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Strobe tally, sampled on the falling edge mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.o_press[i]) pressCount[i]++;
      if (bus.o_release[i]) releaseCount[i]++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] btnN);
    bus.i_btn_n = btnN;
  endtask

  task automatic waitSteps(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    nreset = 1'b0;
    applyStimulus(4'b1111);
    waitSteps(2);
    checkOutput("rst_pressed", 32'(bus.o_pressed), 32'h0);
    checkOutput("rst_press", 32'(bus.o_press), 32'h0);
    checkOutput("rst_release", 32'(bus.o_release), 32'h0);

    // All four held as reset lifts.
    nreset = 1'b1;
    applyStimulus(4'b0000);
    waitSteps(9);
    checkOutput("all_early", 32'(bus.o_pressed), 32'h0);
    waitSteps(1);
    checkOutput("all_pressed", 32'(bus.o_pressed), 32'hF);
    checkOutput("all_press", 32'(bus.o_press), 32'hF);
    checkOutput("all_norel", 32'(bus.o_release), 32'h0);
    waitSteps(1);
    checkOutput("all_press_1cyc", 32'(bus.o_press), 32'h0);

    // Asynchronous reset mid-cycle, away from any clock edge.
    #2 nreset = 1'b0;
    #1;
    checkOutput("async_pressed", 32'(bus.o_pressed), 32'h0);
    checkOutput("async_press", 32'(bus.o_press), 32'h0);
    waitSteps(1);
    nreset = 1'b1;
    waitSteps(9);
    checkOutput("rehold_early", 32'(bus.o_pressed), 32'h0);
    waitSteps(1);
    checkOutput("rehold_pressed", 32'(bus.o_pressed), 32'hF);
    checkOutput("rehold_press", 32'(bus.o_press), 32'hF);
    waitSteps(1);
    checkOutput("no_rel_on_reset", 32'(releaseCount[0] + releaseCount[1] +
                releaseCount[2] + releaseCount[3]), 32'd0);

    applyStimulus(4'b1111);
    waitSteps(10);
    checkOutput("relall_release", 32'(bus.o_release), 32'hF);
    checkOutput("relall_pressed", 32'(bus.o_pressed), 32'h0);
    waitSteps(2);

    // Clean press on bit 0.
    applyStimulus(4'b1110);
    waitSteps(9);
    checkOutput("b0_early", 32'(bus.o_pressed), 32'h0);
    waitSteps(1);
    checkOutput("b0_pressed", 32'(bus.o_pressed), 32'h1);
    checkOutput("b0_press", 32'(bus.o_press), 32'h1);
    checkOutput("b0_norel", 32'(bus.o_release), 32'h0);
    waitSteps(1);
    checkOutput("b0_press_1cyc", 32'(bus.o_press), 32'h0);

    // Seven-sample low glitch on bit 1 is rejected.
    p1 = pressCount[1];
    applyStimulus(4'b1100);
    waitSteps(7);
    applyStimulus(4'b1110);
    waitSteps(15);
    checkOutput("glitch_lo_level", 32'(bus.o_pressed), 32'h1);
    checkOutput("glitch_lo_nopress", 32'(pressCount[1] - p1), 32'd0);

    // Real press on bit 1, then a seven-sample high glitch is rejected.
    applyStimulus(4'b1100);
    waitSteps(12);
    checkOutput("b1_pressed", 32'(bus.o_pressed), 32'h3);
    p1 = pressCount[1];
    r1 = releaseCount[1];
    applyStimulus(4'b1110);
    waitSteps(7);
    applyStimulus(4'b1100);
    waitSteps(15);
    checkOutput("glitch_hi_level", 32'(bus.o_pressed), 32'h3);
    checkOutput("glitch_hi_nopress", 32'(pressCount[1] - p1), 32'd0);
    checkOutput("glitch_hi_norel", 32'(releaseCount[1] - r1), 32'd0);

    // Bits 2 and 3 pressed on the same edge.
    applyStimulus(4'b0000);
    waitSteps(9);
    checkOutput("b23_early", 32'(bus.o_press), 32'h0);
    waitSteps(1);
    checkOutput("b23_press", 32'(bus.o_press), 32'hC);
    checkOutput("b23_pressed", 32'(bus.o_pressed), 32'hF);
    waitSteps(2);

    // Release bit 0, then release bit 2 and press bit 0 together.
    applyStimulus(4'b0001);
    waitSteps(12);
    checkOutput("b0_off", 32'(bus.o_pressed), 32'hE);
    applyStimulus(4'b0100);
    waitSteps(10);
    checkOutput("mix_press", 32'(bus.o_press), 32'h1);
    checkOutput("mix_release", 32'(bus.o_release), 32'h4);
    checkOutput("mix_pressed", 32'(bus.o_pressed), 32'hB);
    waitSteps(2);

    // Reset while bit 3 is pending with counter at 5.
    applyStimulus(4'b1111);
    waitSteps(12);
    checkOutput("idle_pressed", 32'(bus.o_pressed), 32'h0);
    p3 = pressCount[3];
    applyStimulus(4'b0111);
    waitSteps(7);
    nreset = 1'b0;
    waitSteps(2);
    nreset = 1'b1;
    waitSteps(9);
    checkOutput("pend_rst_level", 32'(bus.o_pressed), 32'h0);
    checkOutput("pend_rst_nopress", 32'(pressCount[3] - p3), 32'd0);
    waitSteps(1);
    checkOutput("pend_rst_press", 32'(bus.o_press), 32'h8);
    checkOutput("pend_rst_pressed", 32'(bus.o_pressed), 32'h8);

    // Long hold on bit 0.
    applyStimulus(4'b1111);
    waitSteps(12);
    checkOutput("idle2_pressed", 32'(bus.o_pressed), 32'h0);
    p0 = pressCount[0];
    applyStimulus(4'b1110);
    waitSteps(10);
    checkOutput("hold_accept", 32'(bus.o_press), 32'h1);
`ifdef BUTTON_REPEAT_EN
    waitSteps(19);
    checkOutput("rep_early", 32'(bus.o_press), 32'h0);
    waitSteps(1);
    checkOutput("rep_first", 32'(bus.o_press), 32'h1);
    waitSteps(4);
    checkOutput("rep_gap", 32'(bus.o_press), 32'h0);
    waitSteps(1);
    checkOutput("rep_second", 32'(bus.o_press), 32'h1);
    waitSteps(5);
    checkOutput("rep_third", 32'(bus.o_press), 32'h1);
    checkOutput("rep_count", 32'(pressCount[0] - p0), 32'd4);
`else
    waitSteps(60);
    checkOutput("hold_count", 32'(pressCount[0] - p0), 32'd1);
    checkOutput("hold_level", 32'(bus.o_pressed), 32'h1);
`endif
    applyStimulus(4'b1111);
    waitSteps(12);
    checkOutput("final_pressed", 32'(bus.o_pressed), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule
